// File: rtl/evr_tx_scheduler.sv
// EVR transmit word builder for the GTP TX lane.
// Lane 0 carries periodic K28.5 commas and queued event codes.
// Lane 1 interleaves distributed-bus bytes (even slots) with segment frames (odd slots).
//
// Segment FSM states (the state is the byte type that goes out on the next odd slot)
//   state    | meaning
//   S_IDLE   | no frame; lane 1 odd slots send 0x00, new frame may be accepted
//   S_START  | frame accepted, K28.2 (0x5C) start symbol pending
//   S_ADDR   | segment address byte pending
//   S_DATA   | payload bytes pending, read one cycle ahead from the external buffer
//   S_STOP   | K28.1 (0x3C) stop symbol pending
//   S_CSUM_H | checksum high byte pending
//   S_CSUM_L | checksum low byte pending; seg_done follows
module evr_tx_scheduler #(
  parameter int COMMA_PERIOD = 4,
  parameter int SEG_BYTES    = 16
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        ev_valid,
  input  logic [7:0]  ev_code,
  output logic        ev_ready,
  input  logic [7:0]  dbus_in,
  input  logic        seg_valid,
  input  logic [7:0]  seg_addr,
  output logic        seg_ready,
  output logic        seg_rd_en,
  output logic [((SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1)-1:0] seg_rd_idx,
  input  logic [7:0]  seg_rd_data,
  output logic        seg_done,
  output logic        seg_abort,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_is_k
);

  localparam int SW = $clog2(COMMA_PERIOD);
  localparam int IW = (SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(COMMA_PERIOD - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(SEG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_CSUM_H, S_CSUM_L
  } seg_state_t;

  seg_state_t      state, state_nxt;
  logic [SW-1:0]   slot, slot_nxt;
  logic            slot_odd;
  logic [7:0]      ev_hold;
  logic            ev_hold_v;
  logic [7:0]      addr_q;
  logic [IW-1:0]   byte_cnt;
  logic [15:0]     sum;
  logic [15:0]     csum;
  logic [7:0]      seg_byte;
  logic            seg_k;
  logic [7:0]      lane0, lane1;
  logic            lane0_k, lane1_k;

  assign slot_odd   = slot[0];
  assign slot_nxt   = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
  // Reset gating keeps the handshakes low while the link is held in reset.
  assign ev_ready   = !reset && ready && (slot_nxt != '0);
  assign seg_ready  = !reset && ready && (state == S_IDLE);
  assign seg_rd_en  = ready && (state == S_DATA) && !slot_odd;
  assign seg_rd_idx = byte_cnt;
  assign csum       = 16'hFFFF - sum;

  // Segment FSM state register.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Segment FSM next state and the lane-1 byte it offers for the coming odd slot.
  always_comb begin
    state_nxt = state;
    seg_byte  = 8'h00;
    seg_k     = 1'b0;
    if (!ready) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (seg_valid) state_nxt = S_START;
        S_START:  begin seg_byte = 8'h5C; seg_k = 1'b1; if (slot_odd) state_nxt = S_ADDR; end
        S_ADDR:   begin seg_byte = addr_q; if (slot_odd) state_nxt = S_DATA; end
        S_DATA:   begin
          seg_byte = seg_rd_data;
          if (slot_odd && byte_cnt == BYTE_LAST) state_nxt = S_STOP;
        end
        S_STOP:   begin seg_byte = 8'h3C; seg_k = 1'b1; if (slot_odd) state_nxt = S_CSUM_H; end
        S_CSUM_H: begin seg_byte = csum[15:8]; if (slot_odd) state_nxt = S_CSUM_L; end
        S_CSUM_L: begin seg_byte = csum[7:0]; if (slot_odd) state_nxt = S_IDLE; end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Lane muxing for the word registered at this edge.
  always_comb begin
    lane0   = 8'h00;
    lane0_k = 1'b0;
    if (slot == '0) begin
      lane0   = 8'hBC;
      lane0_k = 1'b1;
    end else if (ev_hold_v) begin
      lane0 = ev_hold;
    end
    lane1   = slot_odd ? seg_byte : dbus_in;
    lane1_k = slot_odd & seg_k;
  end

  // Slot counter, output word, event holding register and frame datapath.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      slot      <= '0;
      tx_data   <= 16'h0000;
      tx_is_k   <= 2'b00;
      ev_hold   <= 8'h00;
      ev_hold_v <= 1'b0;
      addr_q    <= 8'h00;
      byte_cnt  <= '0;
      sum       <= 16'h0000;
      seg_done  <= 1'b0;
      seg_abort <= 1'b0;
    end else if (!ready) begin
      slot      <= '0;
      tx_data   <= 16'h0000;
      tx_is_k   <= 2'b00;
      ev_hold_v <= 1'b0;
      byte_cnt  <= '0;
      seg_done  <= 1'b0;
      seg_abort <= (state != S_IDLE);
    end else begin
      slot      <= slot_nxt;
      tx_data   <= {lane1, lane0};
      tx_is_k   <= {lane1_k, lane0_k};
      ev_hold_v <= ev_valid && ev_ready;
      ev_hold   <= ev_code;
      seg_abort <= 1'b0;
      seg_done  <= slot_odd && (state == S_CSUM_L);
      if (state == S_IDLE && seg_valid) addr_q <= seg_addr;
      if (slot_odd && state == S_ADDR) begin
        sum      <= {8'h00, addr_q};
        byte_cnt <= '0;
      end
      if (slot_odd && state == S_DATA) begin
        sum      <= sum + {8'h00, seg_rd_data};
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_evr_tx_scheduler.sv
// Bench for evr_tx_scheduler: queue-based frame model plus slot arithmetic, random and directed traffic.
module tb_evr_tx_scheduler;
  localparam int CP = 4;
  localparam int SB = 16;

  logic        tx_clk = 1'b0;
  logic        reset, ready, ev_valid, seg_valid;
  logic [7:0]  ev_code, dbus_in, seg_addr, seg_rd_data;
  logic        ev_ready, seg_ready, seg_rd_en, seg_done, seg_abort;
  logic [3:0]  seg_rd_idx;
  logic [15:0] tx_data;
  logic [1:0]  tx_is_k;

  logic [7:0]  mem [SB];

  typedef struct {
    logic       k;
    logic [7:0] b;
    bit         is_data;
    int         idx;
  } fbyte_t;

  fbyte_t     fq[$];
  int         mslot;
  bit         m_busy, ev_pend;
  logic [7:0] ev_val;
  int         n_cmp = 0, n_bad = 0, n_done = 0;
  logic [7:0] odd_h0, odd_h1;

  evr_tx_scheduler #(.COMMA_PERIOD(CP), .SEG_BYTES(SB)) dut (
    .tx_clk(tx_clk), .reset(reset), .ready(ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
    .dbus_in(dbus_in),
    .seg_valid(seg_valid), .seg_addr(seg_addr), .seg_ready(seg_ready),
    .seg_rd_en(seg_rd_en), .seg_rd_idx(seg_rd_idx), .seg_rd_data(seg_rd_data),
    .seg_done(seg_done), .seg_abort(seg_abort),
    .tx_data(tx_data), .tx_is_k(tx_is_k)
  );

  always #5 tx_clk = ~tx_clk;

  // External payload buffer: one-cycle read latency.
  always @(posedge tx_clk) if (seg_rd_en) seg_rd_data <= mem[seg_rd_idx];

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mslot   = 0;
    m_busy  = 0;
    ev_pend = 0;
    fq.delete();
  endtask

  task automatic build_frame();
    logic [15:0] s;
    s = {8'h00, seg_addr};
    fq.push_back('{1'b1, 8'h5C, 1'b0, 0});
    fq.push_back('{1'b0, seg_addr, 1'b0, 0});
    for (int i = 0; i < SB; i++) begin
      fq.push_back('{1'b0, mem[i], 1'b1, i});
      s = s + {8'h00, mem[i]};
    end
    fq.push_back('{1'b1, 8'h3C, 1'b0, 0});
    s = 16'hFFFF - s;
    fq.push_back('{1'b0, s[15:8], 1'b0, 0});
    fq.push_back('{1'b0, s[7:0], 1'b0, 0});
  endtask

  // One clock: check handshakes before the edge, predict the word, check it after the edge.
  task automatic step();
    logic xe, xs, xr, xdone, xabort, rdy;
    logic [15:0] xd;
    logic [1:0]  xk;
    bit odd;
    #1;
    xe = ready && ((mslot + 1) % CP != 0);
    xs = ready && !m_busy;
    xr = ready && m_busy && fq.size() > 0 && fq[0].is_data && (mslot % 2 == 0);
    chk("ev_ready", ev_ready, xe);
    chk("seg_ready", seg_ready, xs);
    chk("seg_rd_en", seg_rd_en, xr);
    if (xr) chk("seg_rd_idx", seg_rd_idx, fq[0].idx);
    xd = 16'h0; xk = 2'b0; xdone = 0; xabort = 0;
    odd = (mslot % 2 == 1);
    rdy = ready;
    if (!ready) begin
      xabort = m_busy;
      model_reset();
    end else begin
      if (mslot % CP == 0) begin xd[7:0] = 8'hBC; xk[0] = 1'b1; end
      else if (ev_pend) xd[7:0] = ev_val;
      ev_pend = ev_valid && xe;
      ev_val  = ev_code;
      if (!odd) xd[15:8] = dbus_in;
      else if (m_busy) begin
        xd[15:8] = fq[0].b;
        xk[1]    = fq[0].k;
        void'(fq.pop_front());
        if (fq.size() == 0) begin m_busy = 0; xdone = 1; end
      end
      if (seg_valid && xs) begin build_frame(); m_busy = 1; end
      mslot = (mslot + 1) % CP;
    end
    @(posedge tx_clk); #1;
    chk("tx_data", tx_data, xd);
    chk("tx_is_k", tx_is_k, xk);
    chk("seg_done", seg_done, xdone);
    chk("seg_abort", seg_abort, xabort);
    if (rdy && odd) begin odd_h1 = odd_h0; odd_h0 = tx_data[15:8]; end
    if (xdone) n_done++;
    @(negedge tx_clk);
  endtask

  task automatic start_frame();
    int k;
    seg_valid = 1;
    k = 0;
    while (!m_busy && k < 20) begin step(); k++; end
    seg_valid = 0;
    if (!m_busy) chk("accept_timeout", 0, 1);
  endtask

  task automatic finish_frame();
    int d0, k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < 200) begin step(); k++; end
    if (n_done == d0) chk("frame_timeout", 0, 1);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < SB; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int k;
    logic [7:0] p4 [8];
    p4 = '{8'hAD, 8'h74, 8'hAD, 8'h74, 8'h7A, 8'h34, 8'h74, 8'hAD};
    reset = 1; ready = 0; ev_valid = 0; ev_code = 0; dbus_in = 0;
    seg_valid = 0; seg_addr = 0; seg_rd_data = 0;
    odd_h0 = 0; odd_h1 = 0;
    for (int i = 0; i < SB; i++) mem[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge tx_clk);
    chk("rst_tx_data", tx_data, 16'h0);
    chk("rst_tx_is_k", tx_is_k, 2'b0);
    chk("rst_ev_ready", ev_ready, 1'b0);
    chk("rst_seg_ready", seg_ready, 1'b0);
    chk("rst_seg_rd_en", seg_rd_en, 1'b0);
    chk("rst_seg_rd_idx", seg_rd_idx, 4'h0);
    chk("rst_seg_done", seg_done, 1'b0);
    chk("rst_seg_abort", seg_abort, 1'b0);
    reset = 0;
    repeat (2) step();

    // Idle stream with constant dbus.
    ready = 1; dbus_in = 8'hA5;
    repeat (12) step();

    // Continuous event request.
    ev_valid = 1; ev_code = 8'h7E;
    repeat (12) step();
    ev_valid = 0;

    // Frame with known checksum FCF0.
    mem = '{8'h00, 8'h8B, 8'hFC, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h07,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    seg_addr = 8'hFF;
    start_frame();
    finish_frame();
    chk("t3_csum", {odd_h1, odd_h0}, 16'hFCF0);

    // Frame with known checksum F7D9.
    for (int i = 0; i < SB; i++) mem[i] = p4[i % 8];
    seg_addr = 8'h04;
    start_frame();
    finish_frame();
    chk("t4_csum", {odd_h1, odd_h0}, 16'hF7D9);

    // Link drop during payload byte 5.
    rand_mem();
    seg_addr = 8'($urandom);
    start_frame();
    k = 0;
    while (!(fq.size() > 0 && fq[0].is_data && fq[0].idx == 5) && k < 100) begin step(); k++; end
    if (k == 100) chk("t5_wait", 0, 1);
    ready = 0;
    step();
    chk("t5_abort", seg_abort, 1'b1);
    chk("t5_no_done", seg_done, 1'b0);
    step();
    ready = 1;
    seg_addr = 8'($urandom);
    start_frame();
    finish_frame();

    // Back-to-back frames with seg_valid held, then async reset mid-frame.
    rand_mem();
    seg_valid = 1;
    for (int i = 0; i < 150; i++) begin
      ev_valid = 1'($urandom);
      ev_code  = 8'($urandom);
      dbus_in  = 8'($urandom);
      seg_addr = 8'($urandom);
      step();
    end
    k = 0;
    while (!(m_busy && fq.size() > 0 && fq[0].is_data) && k < 100) begin step(); k++; end
    #2 reset = 1;
    #1;
    chk("arst_tx_data", tx_data, 16'h0);
    chk("arst_tx_is_k", tx_is_k, 2'b0);
    chk("arst_ev_ready", ev_ready, 1'b0);
    chk("arst_seg_ready", seg_ready, 1'b0);
    chk("arst_seg_rd_en", seg_rd_en, 1'b0);
    model_reset();
    @(negedge tx_clk);
    reset = 0;
    seg_valid = 0;

    // Random traffic including short link drops.
    for (int i = 0; i < 800; i++) begin
      ready     = ($urandom_range(0, 99) != 0);
      ev_valid  = 1'($urandom);
      ev_code   = 8'($urandom);
      dbus_in   = 8'($urandom);
      seg_valid = ($urandom_range(0, 3) == 0);
      seg_addr  = 8'($urandom);
      if (!m_busy) mem[$urandom_range(0, SB - 1)] = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
